cp0_unit: RTL and testbench

//  Parametrised coprocessor-0 for the pipelined MIPS core, at M stage: holds SR/Cause/EPC/PRId, arbitrates

---
 rtl/cp0_unit.sv | 131 +++++++++++++
 tb/tb_cp0_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core (M stage): SR/Cause/EPC/PRId, interrupt/exception take, ERET.
// Define CP0_TIMER_EN to add the Count/Compare timer driving IP[15].
module cp0_unit #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h12345678
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_pc,
  input  logic                 exc_bd,
  input  logic                 eret,
  output logic                 int_req,
  output logic [31:0]          epc
);

  logic [5:0]  im;
  logic [5:0]  ip;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exc_code_r;
  logic [31:0] epc_r;

  logic [5:0]  hw6;
  logic [5:0]  ip_live;
  logic [5:0]  ip_rd;
  logic        irq;
  logic        exc;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] epc_take;
  logic        unused_bits;

  always_comb begin
    hw6 = '0;
    for (int i = 0; i < NUM_HWINT; i++) hw6[i] = hw_int[i];
  end

  assign sr_wr       = wr_en && (wr_addr == 5'd12);
  assign epc_wr      = wr_en && (wr_addr == 5'd14);
  assign epc_take    = {exc_pc[31:2], 2'b00} - (exc_bd ? 32'd4 : 32'd0);
  assign unused_bits = ^exc_pc[1:0];

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        tmr_pend;
  logic [31:0] count_nxt;

  assign count_nxt = (wr_en && (wr_addr == 5'd9)) ? wr_data : count + 32'd1;

  // Pending latches on the post-increment match and holds until Compare is rewritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      compare  <= '0;
      tmr_pend <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wr_en && (wr_addr == 5'd11)) begin
        compare  <= wr_data;
        tmr_pend <= 1'b0;
      end else if (count_nxt == compare) begin
        tmr_pend <= 1'b1;
      end
    end
  end

  assign ip_live = {tmr_pend, hw6[4:0]};
  assign ip_rd   = {tmr_pend, ip[4:0]};
`else
  assign ip_live = hw6;
  assign ip_rd   = ip;
`endif

  assign irq     = (|(ip_live & im)) && ie && !exl;
  assign exc     = (exc_code != 5'd0) && !exl;
  assign int_req = irq || exc;
  assign epc     = epc_r;

  // Later assignments win: take overrides MTC0 and ERET on EXL/EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      im         <= '0;
      ip         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      exc_code_r <= '0;
      epc_r      <= '0;
    end else begin
      ip <= hw6;
      if (sr_wr) begin
        im  <= wr_data[15:10];
        exl <= wr_data[1];
        ie  <= wr_data[0];
      end
      if (epc_wr) epc_r <= {wr_data[31:2], 2'b00};
      if (eret) exl <= 1'b0;
      if (int_req) begin
        exl        <= 1'b1;
        bd         <= exc_bd;
        epc_r      <= epc_take;
        exc_code_r <= irq ? 5'd0 : exc_code;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
`ifdef CP0_TIMER_EN
      5'd9:  rd_data = count;
      5'd11: rd_data = compare;
`endif
      5'd12: rd_data = {16'b0, im, 8'b0, exl, ie};
      5'd13: rd_data = {bd, 15'b0, ip_rd, 3'b0, exc_code_r, 2'b00};
      5'd14: rd_data = epc_r;
      5'd15: rd_data = PRID_VAL;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit (default build): directed scenarios followed by randomized cycles.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h12345678;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  hw_int;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic        int_req;
  logic [31:0] epc;

  cp0_unit #(.NUM_HWINT(6), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hw_int(hw_int),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret),
    .int_req(int_req), .epc(epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        ireq;
    logic [4:0]  addr;
    logic [31:0] rd;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   ncyc       = 0;

  // Reference model: architectural registers as whole 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic quiet();
    reset = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    hw_int = 6'h0; exc_code = 5'd0; exc_pc = 32'h0; exc_bd = 1'b0; eret = 1'b0;
    rd_addr = 5'd0;
  endtask

  task automatic step();
    exp_t        e;
    logic        irq, exc, take;
    logic [31:0] n_sr, n_cause, n_epc;
    irq  = ((hw_int & m_sr[15:10]) != 6'h0) && m_sr[0] && !m_sr[1];
    exc  = (exc_code != 5'd0) && !m_sr[1];
    take = irq || exc;
    e.id = ncyc; e.ireq = take; e.addr = rd_addr; e.rd = model_read(rd_addr); e.epc = m_epc;
    sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      n_sr = m_sr;
      if (wr_en && wr_addr == 5'd12) n_sr = wr_data & 32'h0000FC03;
      if (eret) n_sr[1] = 1'b0;
      if (take) n_sr[1] = 1'b1;
      n_cause = (m_cause & ~32'h0000FC00) | (32'(hw_int) << 10);
      n_epc = m_epc;
      if (wr_en && wr_addr == 5'd14) n_epc = wr_data & ~32'h3;
      if (take) begin
        n_cause = (n_cause & 32'h0000FC00) | (32'(exc_bd) << 31)
                | (32'(irq ? 5'd0 : exc_code) << 2);
        n_epc = (exc_pc & ~32'h3) - (exc_bd ? 32'd4 : 32'd0);
      end
      m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    end
    ncyc++;
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    quiet(); rd_addr = a; step();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    quiet(); wr_en = 1'b1; wr_addr = a; wr_data = d; rd_addr = a; step();
  endtask

  // Monitor: every cycle with an outstanding expectation is checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (int_req !== e.ireq || rd_data !== e.rd || epc !== e.epc) begin
          miscompares++;
          $display("FAIL cycle%0d rd%0d: got int_req=%b rd_data=%h epc=%h, expected int_req=%b rd_data=%h epc=%h",
                   e.id, e.addr, int_req, rd_data, epc, e.ireq, e.rd, e.epc);
        end
      end
    end
  end

  initial begin
    int r;
    int budget;
    quiet();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1; step();

    // Reset values
    rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd15); rd(5'd9); rd(5'd11);

    // External interrupt on IP[10], then ERET
    mtc0(5'd12, 32'h0000_0401);
    quiet(); hw_int = 6'h01; exc_pc = 32'h3008; rd_addr = 5'd13; step();
    quiet(); hw_int = 6'h01; rd_addr = 5'd14; step();
    quiet(); hw_int = 6'h3F; rd_addr = 5'd13; step();
    quiet(); hw_int = 6'h01; rd_addr = 5'd12; step();
    quiet(); hw_int = 6'h01; eret = 1'b1; rd_addr = 5'd12; step();
    rd(5'd12);

    // Synchronous exception in a delay slot with interrupts disabled
    mtc0(5'd12, 32'h0);
    quiet(); exc_code = 5'd10; exc_bd = 1'b1; exc_pc = 32'h3010; rd_addr = 5'd14; step();
    rd(5'd14); rd(5'd13);
    quiet(); exc_code = 5'd7; exc_pc = 32'h9000; rd_addr = 5'd13; step();
    quiet(); eret = 1'b1; step();

    // Interrupt beats exception; take beats MTC0 EPC
    mtc0(5'd12, 32'h0000_FC01);
    quiet(); hw_int = 6'h20; exc_code = 5'd4; exc_pc = 32'h5002;
    wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h4001; rd_addr = 5'd14; step();
    rd(5'd14); rd(5'd13); rd(5'd12);
    quiet(); eret = 1'b1; step();
    mtc0(5'd14, 32'h4001); rd(5'd14);

    // Read-only registers ignore writes
    mtc0(5'd13, 32'hFFFF_FFFF); rd(5'd13);
    mtc0(5'd15, 32'h0); rd(5'd15);

    // Reset while EXL=1 and interrupts pending
    quiet(); exc_code = 5'd12; exc_pc = 32'h7000; step();
    quiet(); hw_int = 6'h3F; reset = 1'b1; step();
    quiet(); hw_int = 6'h3F; rd_addr = 5'd12; step();
    quiet(); hw_int = 6'h3F; rd_addr = 5'd14; step();

    // Randomized cycles
    for (int i = 0; i < 3000; i++) begin
      quiet();
      reset    = ($urandom_range(0, 99) < 2);
      hw_int   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      exc_code = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      exc_pc   = $urandom;
      exc_bd   = $urandom_range(0, 1) == 1;
      eret     = ($urandom_range(0, 9) == 0);
      wr_en    = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 6);
      wr_addr  = (r < 3) ? 5'd12 : (r == 3) ? 5'd14 : (r == 4) ? 5'd13 : 5'($urandom);
      wr_data  = $urandom;
      if (wr_addr == 5'd12) wr_data[1] = ($urandom_range(0, 3) == 0);
      if (wr_en && wr_addr == 5'd12) eret = 1'b0;
      rd_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      step();
    end

    quiet();
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
